// File: rtl/suffix_unhash.sv
// suffix_unhash: iterative inverse of the 33-multiply/XOR string hash.
// Peels a known suffix off a target hash, one character per cycle.
module suffix_unhash #(
    parameter int NUM_CHARS = 8,
    parameter int CHAR_W    = 7,
    localparam int LEN_W    = $clog2(NUM_CHARS + 1),
    localparam int SUF_W    = CHAR_W * NUM_CHARS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_hash,
    input  logic [SUF_W-1:0] in_suffix,
    input  logic [LEN_W-1:0] in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_hash,
    output logic [SUF_W-1:0] out_suffix,
    output logic [LEN_W-1:0] out_len
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [31:0]      INV33   = 32'h3E0F83E1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(NUM_CHARS);

    state_t             state;
    logic [LEN_W-1:0]   idx;
    logic [LEN_W-1:0]   len_clamp;
    logic [CHAR_W-1:0]  cur_char;
    logic [31:0]        step;

    assign len_clamp = (in_len > MAX_LEN) ? MAX_LEN : in_len;

    always_comb begin
        cur_char = '0;
        for (int k = 0; k < NUM_CHARS; k++) begin
            if (idx == LEN_W'(k)) cur_char = out_suffix[CHAR_W*k +: CHAR_W];
        end
    end

    // Multiplying by 33^-1 undoes the forward *33 modulo 2^32.
    assign step = (out_hash ^ {{(32-CHAR_W){1'b0}}, cur_char}) * INV33;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_hash   <= '0;
            out_suffix <= '0;
            out_len    <= '0;
            idx        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_hash   <= in_hash;
                        out_suffix <= in_suffix;
                        out_len    <= len_clamp;
                        in_ready   <= 1'b0;
                        if (len_clamp == '0) begin
                            idx       <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx   <= len_clamp - 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    out_hash <= step;
                    if (idx == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_suffix_unhash.sv
// tb_suffix_unhash: directed table, corner sequences and random jobs
// checked against a forward-hash model.
module tb_suffix_unhash;

    localparam int NC = 8;
    localparam int CW = 7;
    localparam int LW = 4;
    localparam int SW = NC * CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_hash = '0;
    logic [SW-1:0] in_suffix = '0;
    logic [LW-1:0] in_len = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_hash;
    logic [SW-1:0] out_suffix;
    logic [LW-1:0] out_len;

    int compared = 0;
    int mismatched = 0;

    suffix_unhash #(.NUM_CHARS(NC), .CHAR_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_hash   (in_hash),
        .in_suffix (in_suffix),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hash  (out_hash),
        .out_suffix(out_suffix),
        .out_len   (out_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   hash;
        logic [SW-1:0] suffix;
        logic [LW-1:0] len;
        logic [31:0]   exp_hash;
        logic [LW-1:0] exp_len;
    } vec_t;

    function automatic logic [31:0] fwd(input logic [31:0] seed,
                                        input logic [SW-1:0] s,
                                        input int n);
        logic [31:0] h;
        h = seed;
        for (int k = 0; k < n; k++)
            h = (h * 32'd33) ^ {25'b0, s[CW*k +: CW]};
        return h;
    endfunction

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Offers one job, waits for the result, checks echoes/latency, handshakes.
    task automatic run_job(input string tag, input logic [31:0] h,
                           input logic [SW-1:0] s, input logic [LW-1:0] l,
                           input logic [31:0] eh, input logic [LW-1:0] el,
                           input logic pre_rdy);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_hash = h;
        in_suffix = s;
        in_len = l;
        out_ready = pre_rdy;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_hash = $urandom;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(el));
        check({tag, " hash"}, 64'(out_hash), 64'(eh));
        check({tag, " suffix"}, 64'(out_suffix), 64'(s));
        check({tag, " len"}, 64'(out_len), 64'(el));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " valid drop"}, 64'(out_valid), 64'd0);
        check({tag, " ready rise"}, 64'(in_ready), 64'd1);
    endtask

    vec_t vecs[5];

    initial begin
        logic [31:0]   seed;
        logic [SW-1:0] s;
        logic [LW-1:0] l;
        int            cl;
        logic [31:0]   held;

        vecs[0] = '{32'd177604, 56'h61, 4'd1, 32'd5381, 4'd1};
        vecs[1] = '{32'd5860902, 56'h3161, 4'd2, 32'd5381, 4'd2};
        vecs[2] = '{32'hFFFFFFA0, 56'h7F, 4'd1, 32'hFFFFFFFF, 4'd1};
        vecs[3] = '{32'h12345678, 56'hABCDEF012345, 4'd0, 32'h12345678, 4'd0};
        s = 56'h1F2E3D4C5B6A79;
        vecs[4] = '{fwd(32'hDEADBEEF, s, 8), s, 4'd15, 32'hDEADBEEF, 4'd8};

        #12;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_hash", 64'(out_hash), 64'd0);
        check("reset out_suffix", 64'(out_suffix), 64'd0);
        check("reset out_len", 64'(out_len), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_job($sformatf("vec%0d", i), vecs[i].hash, vecs[i].suffix,
                    vecs[i].len, vecs[i].exp_hash, vecs[i].exp_len, 1'b0);

        // Backpressure: result held, new offers ignored.
        s = 56'h0A0B0C;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_hash = fwd(32'h0BADF00D, s, 2);
        in_suffix = s;
        in_len = 4'd2;
        @(posedge clk); #1;
        in_hash = 32'h55555555;
        in_len = 4'd0;
        for (int c = 0; c < 3 && !out_valid; c++) begin
            @(posedge clk); #1;
        end
        check("bp valid", 64'(out_valid), 64'd1);
        held = out_hash;
        check("bp hash", 64'(held), 64'h0BADF00D);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp hold valid", 64'(out_valid), 64'd1);
            check("bp hold ready", 64'(in_ready), 64'd0);
            check("bp hold hash", 64'(out_hash), 64'h0BADF00D);
            check("bp hold len", 64'(out_len), 64'd2);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp release valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bp no ghost job", 64'(out_valid), 64'd0);
        check("bp idle ready", 64'(in_ready), 64'd1);

        // Reset mid-RUN aborts the job.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_hash = 32'hCAFEBABE;
        in_suffix = 56'h123456789ABCDE;
        in_len = 4'd8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("run ready low", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort valid", 64'(out_valid), 64'd0);
        check("abort hash", 64'(out_hash), 64'd0);
        check("abort len", 64'(out_len), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after abort ready", 64'(in_ready), 64'd1);
        check("after abort valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < 1000; i++) begin
            seed = $urandom;
            s = {$urandom, $urandom};
            l = LW'($urandom_range(0, (i % 10 == 0) ? 15 : 8));
            cl = (int'(l) > NC) ? NC : int'(l);
            run_job($sformatf("rnd%0d", i), fwd(seed, s, cl), s, l, seed,
                    LW'(cl), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
